// File: rtl/operand_issue_stage.sv
// ID/EX issue stage: regfile address drive, EX>MEM>WB>RF operand bypass,
// load-use hazard detection and a registered instruction toward execute.
module operand_issue_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [AW-1:0]    in_rs1_addr,
  input  logic [AW-1:0]    in_rs2_addr,
  input  logic             in_uses_rs1,
  input  logic             in_uses_rs2,
  input  logic [AW-1:0]    in_rd_addr,
  input  logic             in_rd_we,
  input  logic             in_is_load,
  output logic [AW-1:0]    rf_rs1_addr,
  output logic [AW-1:0]    rf_rs2_addr,
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  input  logic             ex_valid,
  input  logic [AW-1:0]    ex_rd,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             mem_valid,
  input  logic [AW-1:0]    mem_rd,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_rs1_val,
  output logic [XLEN-1:0]  out_rs2_val,
  output logic [AW-1:0]    out_rd_addr,
  output logic             out_rd_we,
  output logic             out_is_load,
  output logic [CNT_W-1:0] load_use_stalls
);

  logic            ex_fwd, mem_fwd, wb_fwd;
  logic            hazard;
  logic            capture;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign rf_rs1_addr = in_rs1_addr;
  assign rf_rs2_addr = in_rs2_addr;

  // A load in EX has no data yet, so it is excluded from bypass and stalls instead
  assign ex_fwd  = ex_valid & ex_we & ~ex_is_load & (ex_rd != '0);
  assign mem_fwd = mem_valid & mem_we & (mem_rd != '0);
  assign wb_fwd  = wb_we & (wb_rd != '0);

  always_comb begin
    rs1_val = rf_rs1_data;
    if (in_rs1_addr == '0)                   rs1_val = '0;
    else if (ex_fwd  && ex_rd  == in_rs1_addr) rs1_val = ex_data;
    else if (mem_fwd && mem_rd == in_rs1_addr) rs1_val = mem_data;
    else if (wb_fwd  && wb_rd  == in_rs1_addr) rs1_val = wb_data;
  end

  always_comb begin
    rs2_val = rf_rs2_data;
    if (in_rs2_addr == '0)                   rs2_val = '0;
    else if (ex_fwd  && ex_rd  == in_rs2_addr) rs2_val = ex_data;
    else if (mem_fwd && mem_rd == in_rs2_addr) rs2_val = mem_data;
    else if (wb_fwd  && wb_rd  == in_rs2_addr) rs2_val = wb_data;
  end

  assign hazard = in_valid & ex_valid & ex_we & ex_is_load & (ex_rd != '0) &
                  ((in_uses_rs1 & (ex_rd == in_rs1_addr)) |
                   (in_uses_rs2 & (ex_rd == in_rs2_addr)));

  assign in_ready = ~hazard & (~out_valid | out_ready);
  assign capture  = in_valid & in_ready & ~flush;

  // Output register: flush beats capture beats drain; otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rd_addr <= '0;
      out_rd_we   <= 1'b0;
      out_is_load <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_rs1_val <= rs1_val;
      out_rs2_val <= rs2_val;
      out_rd_addr <= in_rd_addr;
      out_rd_we   <= in_rd_we;
      out_is_load <= in_is_load;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating load-use stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_use_stalls <= '0;
    end else if (hazard && !flush && load_use_stalls != '1) begin
      load_use_stalls <= load_use_stalls + CNT_W'(1);
    end
  end

endmodule
